// File: rtl/dqn_pkg.sv
// Shared constants and FSM encoding for the DQN training datapath stages.
package dqn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_OUT  = 5;

  localparam logic [3:0] CTRL_IDLE   = 4'b0000;
  localparam logic [3:0] CTRL_UPD_B2 = 4'b0001;

  localparam logic [2:0] IDX_LAST = 3'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, COMMIT} state_t;
endpackage

// File: rtl/sat_mul_q.sv
// Combinational fixed-point multiply: signed a*b, arithmetic shift by FRAC_W,
// saturate back to DATA_W. Shared by the bias and weight gradient stages.
module sat_mul_q #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_y
);
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_shr;

  // In range when every bit above the result sign matches it.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [2*DATA_W-1:0] v);
    if (v[2*DATA_W-1:DATA_W-1] == {(DATA_W+1){v[2*DATA_W-1]}})
      return v[DATA_W-1:0];
    else if (v[2*DATA_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign w_prod = i_a * i_b;
  assign w_shr  = w_prod >>> FRAC_W;
  assign o_y    = sat(w_shr);
endmodule

// File: rtl/deltab2_gen.sv
// Output-layer bias-gradient stage: five deltas via one shared multiplier,
// committed atomically with a one-cycle update strobe. Option: DELTAB2_CLIP_EN.
import dqn_pkg::*;

module deltab2_gen
`ifdef DELTAB2_CLIP_EN
  #(parameter logic signed [15:0] CLIP = 16'sh0040)
`endif
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] lr,
  input  logic signed [DATA_W-1:0] err_1,
  input  logic signed [DATA_W-1:0] err_2,
  input  logic signed [DATA_W-1:0] err_3,
  input  logic signed [DATA_W-1:0] err_4,
  input  logic signed [DATA_W-1:0] err_5,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               ctrl_o,
  output logic signed [DATA_W-1:0] deltab2_1,
  output logic signed [DATA_W-1:0] deltab2_2,
  output logic signed [DATA_W-1:0] deltab2_3,
  output logic signed [DATA_W-1:0] deltab2_4,
  output logic signed [DATA_W-1:0] deltab2_5
);
  state_t r_state, w_state_nxt;
  logic [2:0] r_idx;
  logic signed [DATA_W-1:0] r_lr;
  logic signed [DATA_W-1:0] r_err    [N_OUT];
  logic signed [DATA_W-1:0] r_shadow [N_OUT];
  logic signed [DATA_W-1:0] r_delta  [N_OUT];
  logic signed [DATA_W-1:0] w_err_sel;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] w_res;
  logic                     w_last;

`ifdef DELTAB2_CLIP_EN
  function automatic logic signed [DATA_W-1:0] clip(input logic signed [DATA_W-1:0] v);
    if (v > CLIP)
      return CLIP;
    else if (v < -CLIP)
      return -CLIP;
    else
      return v;
  endfunction
  assign w_res = clip(w_sat);
`else
  assign w_res = w_sat;
`endif

  always_comb begin
    w_err_sel = '0;
    case (r_idx)
      3'd0:    w_err_sel = r_err[0];
      3'd1:    w_err_sel = r_err[1];
      3'd2:    w_err_sel = r_err[2];
      3'd3:    w_err_sel = r_err[3];
      3'd4:    w_err_sel = r_err[4];
      default: w_err_sel = '0;
    endcase
  end

  sat_mul_q #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
    .i_a (r_lr),
    .i_b (w_err_sel),
    .o_y (w_sat)
  );

  assign w_last = (r_state == CALC) && (r_idx == IDX_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = CALC;
      CALC:    if (r_idx == IDX_LAST) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == LOAD)
        r_idx <= '0;
      else if (r_state == CALC)
        r_idx <= r_idx + 3'd1;
    end
  end

  // Operands are frozen once LOAD has passed, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      r_lr     <= lr;
      r_err[0] <= err_1;
      r_err[1] <= err_2;
      r_err[2] <= err_3;
      r_err[3] <= err_4;
      r_err[4] <= err_5;
    end
  end

  // The last product bypasses the shadow bank so the full set lands on the
  // same edge that raises the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        r_shadow[i] <= '0;
        r_delta[i]  <= '0;
      end
    end else if (r_state == CALC) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (r_idx == 3'(i)) r_shadow[i] <= w_res;
        if (w_last) r_delta[i] <= (r_idx == 3'(i)) ? w_res : r_shadow[i];
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == COMMIT);
  assign ctrl_o    = done ? CTRL_UPD_B2 : CTRL_IDLE;
  assign deltab2_1 = r_delta[0];
  assign deltab2_2 = r_delta[1];
  assign deltab2_3 = r_delta[2];
  assign deltab2_4 = r_delta[3];
  assign deltab2_5 = r_delta[4];
endmodule

// File: tb/tb_deltab2_gen.sv
// Scoreboard bench for deltab2_gen; expected deltas come from a behavioural
// fixed-point model (clip applied when DELTAB2_CLIP_EN is defined).
module tb_deltab2_gen;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] lr = '0;
  logic signed [15:0] err_1 = '0, err_2 = '0, err_3 = '0, err_4 = '0, err_5 = '0;
  logic               busy, done;
  logic [3:0]         ctrl_o;
  logic signed [15:0] deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5;

  typedef struct {
    logic [4:0][15:0] d;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  logic [4:0][15:0] last_exp = '0;
  int               cnt = 0;
  int               n_chk = 0;
  int               n_fail = 0;
  int               n_strobe = 0;

  deltab2_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lr        (lr),
    .err_1     (err_1),
    .err_2     (err_2),
    .err_3     (err_3),
    .err_4     (err_4),
    .err_5     (err_5),
    .busy      (busy),
    .done      (done),
    .ctrl_o    (ctrl_o),
    .deltab2_1 (deltab2_1),
    .deltab2_2 (deltab2_2),
    .deltab2_3 (deltab2_3),
    .deltab2_4 (deltab2_4),
    .deltab2_5 (deltab2_5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdl(input logic signed [15:0] l, input logic signed [15:0] e);
    longint p;
    longint s;
    p = longint'(l) * longint'(e);
    s = p >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef DELTAB2_CLIP_EN
    if (s > 64) s = 64;
    if (s < -64) s = -64;
`endif
    return 16'(s);
  endfunction

  function automatic logic [4:0][15:0] outs();
    return {deltab2_5, deltab2_4, deltab2_3, deltab2_2, deltab2_1};
  endfunction

  // Monitor: strobe pops the scoreboard; otherwise outputs must hold the last set.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ctrl_o != 4'b0000) begin
        exp_t x;
        n_strobe++;
        check_eq("ctrl_o", 80'(ctrl_o), 80'(4'b0001));
        check_eq("done_on_strobe", 80'(done), 80'd1);
        if (sb.size() == 0) begin
          check_eq("unexpected_strobe", 80'd1, 80'd0);
        end else begin
          x = sb.pop_front();
          check_eq("latency", 80'(cnt - x.cyc), 80'd7);
          for (int i = 0; i < 5; i++)
            check_eq($sformatf("deltab2_%0d", i + 1), 80'(outs()[i]), 80'(x.d[i]));
          last_exp = x.d;
        end
      end else begin
        check_eq("hold", {done, outs()}, {1'b0, last_exp});
      end
    end
  end

  task automatic drive_inputs(input logic [15:0] l, input logic [4:0][15:0] e);
    lr = l;
    {err_5, err_4, err_3, err_2, err_1} = e;
  endtask

  task automatic run(input logic [15:0] l, input logic [4:0][15:0] e, input bit poke);
    exp_t x;
    @(posedge clk); #1;
    drive_inputs(l, e);
    start = 1'b1;
    for (int i = 0; i < 5; i++) x.d[i] = mdl(l, e[i]);
    x.cyc = cnt;
    sb.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 20 && busy; k++) begin
      drive_inputs(16'($urandom), {16'($urandom), 16'($urandom), 16'($urandom),
                                   16'($urandom), 16'($urandom)});
      start = poke && (k == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (busy) check_eq("busy_timeout", 80'(busy), 80'd0);
  endtask

  initial begin
    int strobes_before;
    logic [4:0][15:0] e;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_deltas", 80'(outs()), 80'd0);
    check_eq("rst_ctrl", 80'({busy, done, ctrl_o}), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h0019, {16'h0080, 16'h0000, 16'h0200, 16'hFF00, 16'h0100}, 1'b0);
    run(16'h7FFF, {16'h0001, 16'h8000, 16'h8001, 16'h8000, 16'h7FFF}, 1'b0);
    run(16'h0001, {16'h0101, 16'hFF01, 16'h00FF, 16'h0001, 16'hFFFF}, 1'b0);
    run(16'h0000, {16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0100}, 1'b0);
    run(16'h0100, {16'hFFC1, 16'h003F, 16'h8000, 16'hFF00, 16'h0100}, 1'b0);
    run(16'h0033, {16'h0700, 16'hF900, 16'h0011, 16'hFFEE, 16'h0123}, 1'b1);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 5; i++) e[i] = 16'($urandom);
      run(16'($urandom), e, r[0]);
    end
    check_eq("busy_idle", 80'(busy), 80'd0);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    drive_inputs(16'h0100, {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    strobes_before = n_strobe;
    rst_n = 1'b0;
    last_exp = '0;
    #1;
    check_eq("midrst_deltas", 80'(outs()), 80'd0);
    check_eq("midrst_ctrl", 80'({busy, done, ctrl_o}), 80'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("no_strobe_after_rst", 80'(n_strobe), 80'(strobes_before));

    run(16'h0019, {16'h0080, 16'h0000, 16'h0200, 16'hFF00, 16'h0100}, 1'b0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    check_eq("sb_empty", 80'(sb.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
